// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Latches the winner's operation, drives the ALU for the command latency and returns a tagged response.
module alu_arbiter #(
  parameter int DW      = 8,
  parameter int CW      = 4,
  parameter int LAT     = 1,
  parameter int MUL_LAT = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [1:0]      REQ_VALID,
  output logic [1:0]      REQ_READY,
  input  logic [1:0]      REQ_MODE,
  input  logic [2*CW-1:0] REQ_CMD,
  input  logic [3:0]      REQ_INP_VALID,
  input  logic [1:0]      REQ_CIN,
  input  logic [2*DW-1:0] REQ_OPA,
  input  logic [2*DW-1:0] REQ_OPB,
  output logic            ALU_CE,
  output logic            ALU_MODE,
  output logic [CW-1:0]   ALU_CMD,
  output logic [1:0]      ALU_INP_VALID,
  output logic            ALU_CIN,
  output logic [DW-1:0]   ALU_OPA,
  output logic [DW-1:0]   ALU_OPB,
  input  logic [2*DW-1:0] ALU_RES,
  input  logic [5:0]      ALU_FLAGS,
  output logic            RSP_VALID,
  output logic            RSP_ID,
  output logic [2*DW-1:0] RSP_RES,
  output logic [5:0]      RSP_FLAGS
);

  // state | meaning
  // IDLE  | waiting for a request, REQ_READY offered to the round-robin winner
  // BUSY  | ALU driven with the latched operation, counting down the latency
  // RESP  | one-cycle tagged response pulse
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int MAXL = (LAT > MUL_LAT) ? LAT : MUL_LAT;
  localparam int CNTW = $clog2(MAXL + 1);

  state_t          state;
  logic            last_grant;
  logic            grant_id;
  logic [CNTW-1:0] cnt;

  logic            any_req;
  logic            win_id;
  logic            win_mode;
  logic [CW-1:0]   win_cmd;
  logic [1:0]      win_iv;
  logic            win_cin;
  logic [DW-1:0]   win_opa;
  logic [DW-1:0]   win_opb;
  logic            win_mul;
  logic [CNTW-1:0] win_lat;

  always_comb begin
    any_req = |REQ_VALID;
    case (REQ_VALID)
      2'b01:   win_id = 1'b0;
      2'b10:   win_id = 1'b1;
      default: win_id = ~last_grant;
    endcase
    win_mode = REQ_MODE[win_id];
    win_cin  = REQ_CIN[win_id];
    win_cmd  = win_id ? REQ_CMD[2*CW-1:CW]     : REQ_CMD[CW-1:0];
    win_iv   = win_id ? REQ_INP_VALID[3:2]     : REQ_INP_VALID[1:0];
    win_opa  = win_id ? REQ_OPA[2*DW-1:DW]     : REQ_OPA[DW-1:0];
    win_opb  = win_id ? REQ_OPB[2*DW-1:DW]     : REQ_OPB[DW-1:0];
    win_mul  = win_mode && (win_cmd == CW'(9) || win_cmd == CW'(10));
    win_lat  = win_mul ? CNTW'(MUL_LAT) : CNTW'(LAT);
    REQ_READY = 2'b00;
    if (!RST && state == IDLE && any_req)
      REQ_READY[win_id] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      grant_id      <= 1'b0;
      cnt           <= '0;
      ALU_CE        <= 1'b0;
      ALU_MODE      <= 1'b0;
      ALU_CMD       <= '0;
      ALU_INP_VALID <= 2'b00;
      ALU_CIN       <= 1'b0;
      ALU_OPA       <= '0;
      ALU_OPB       <= '0;
      RSP_VALID     <= 1'b0;
      RSP_ID        <= 1'b0;
      RSP_RES       <= '0;
      RSP_FLAGS     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state         <= BUSY;
            last_grant    <= win_id;
            grant_id      <= win_id;
            cnt           <= win_lat;
            ALU_CE        <= 1'b1;
            ALU_MODE      <= win_mode;
            ALU_CMD       <= win_cmd;
            ALU_INP_VALID <= win_iv;
            ALU_CIN       <= win_cin;
            ALU_OPA       <= win_opa;
            ALU_OPB       <= win_opb;
          end
        end
        BUSY: begin
          // Last driven cycle: sample the ALU and release its ports together.
          if (cnt == CNTW'(1)) begin
            state         <= RESP;
            ALU_CE        <= 1'b0;
            ALU_MODE      <= 1'b0;
            ALU_CMD       <= '0;
            ALU_INP_VALID <= 2'b00;
            ALU_CIN       <= 1'b0;
            ALU_OPA       <= '0;
            ALU_OPB       <= '0;
            RSP_VALID     <= 1'b1;
            RSP_ID        <= grant_id;
            RSP_RES       <= ALU_RES;
            RSP_FLAGS     <= ALU_FLAGS;
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        RESP: begin
          RSP_VALID <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: an ALU stand-in with real latency, and a round-robin
// reference model that predicts winner, latency and response for each operation.
module tb_alu_arbiter;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [1:0]    REQ_VALID = 2'b11;
  logic [1:0]    REQ_READY;
  logic [1:0]    REQ_MODE = '0;
  logic [7:0]    REQ_CMD = '0;
  logic [3:0]    REQ_INP_VALID = '0;
  logic [1:0]    REQ_CIN = '0;
  logic [15:0]   REQ_OPA = '0;
  logic [15:0]   REQ_OPB = '0;
  logic          ALU_CE;
  logic          ALU_MODE;
  logic [3:0]    ALU_CMD;
  logic [1:0]    ALU_INP_VALID;
  logic          ALU_CIN;
  logic [7:0]    ALU_OPA;
  logic [7:0]    ALU_OPB;
  logic [15:0]   ALU_RES;
  logic [5:0]    ALU_FLAGS;
  logic          RSP_VALID;
  logic          RSP_ID;
  logic [15:0]   RSP_RES;
  logic [5:0]    RSP_FLAGS;

  alu_arbiter #(.DW(DW), .CW(CW), .LAT(1), .MUL_LAT(2)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_MODE(REQ_MODE),
    .REQ_CMD(REQ_CMD), .REQ_INP_VALID(REQ_INP_VALID), .REQ_CIN(REQ_CIN),
    .REQ_OPA(REQ_OPA), .REQ_OPB(REQ_OPB),
    .ALU_CE(ALU_CE), .ALU_MODE(ALU_MODE), .ALU_CMD(ALU_CMD),
    .ALU_INP_VALID(ALU_INP_VALID), .ALU_CIN(ALU_CIN), .ALU_OPA(ALU_OPA),
    .ALU_OPB(ALU_OPB), .ALU_RES(ALU_RES), .ALU_FLAGS(ALU_FLAGS),
    .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_RES(RSP_RES), .RSP_FLAGS(RSP_FLAGS)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ce_run = 0;
  logic lg_model;

  // Per-requester operation fields
  logic       r_mode [2];
  logic [3:0] r_cmd  [2];
  logic [1:0] r_iv   [2];
  logic       r_cin  [2];
  logic [7:0] r_opa  [2];
  logic [7:0] r_opb  [2];

  // Returns {COUT,OFLOW,G,L,E,ERR,RES}
  function automatic logic [21:0] alu_fn(logic m, logic [3:0] c, logic [1:0] iv,
                                          logic ci, logic [7:0] a, logic [7:0] b);
    logic [15:0] r;
    logic cout, ofl, err;
    r = '0; cout = 1'b0; ofl = 1'b0; err = 1'b0;
    if (iv == 2'b00) err = 1'b1;
    else if (m) begin
      case (c)
        4'd0:  begin r = {8'd0, a} + {8'd0, b} + {15'd0, ci}; cout = r[8]; end
        4'd1:  begin r = {8'd0, a} - {8'd0, b}; ofl = (a < b); end
        4'd9:  r = ({8'd0, a} + 16'd1) * ({8'd0, b} + 16'd1);
        4'd10: r = {7'd0, a, 1'b0} * {8'd0, b};
        default: if (c > 4'd10) err = 1'b1; else r = {8'd0, a ^ b};
      endcase
    end else begin
      if (c > 4'd13) err = 1'b1; else r = {8'd0, a & b};
    end
    return {cout, ofl, (a > b), (a < b), (a == b), err, r};
  endfunction

  function automatic int op_lat(logic m, logic [3:0] c);
    return (m && (c == 4'd9 || c == 4'd10)) ? 2 : 1;
  endfunction

  // ALU stand-in: result valid only in the last cycle of its latency window
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    ce_run <= ALU_CE ? ce_run + 1 : 0;
  end

  always_comb begin
    {ALU_FLAGS, ALU_RES} = {6'b101010, 16'hBAD0};
    if (ALU_CE && ce_run == op_lat(ALU_MODE, ALU_CMD) - 1)
      {ALU_FLAGS, ALU_RES} = alu_fn(ALU_MODE, ALU_CMD, ALU_INP_VALID, ALU_CIN, ALU_OPA, ALU_OPB);
  end

  task automatic set_req(input int i, input logic m, input logic [3:0] c, input logic [1:0] iv,
                         input logic ci, input logic [7:0] a, input logic [7:0] b);
    r_mode[i] = m; r_cmd[i] = c; r_iv[i] = iv; r_cin[i] = ci; r_opa[i] = a; r_opb[i] = b;
    REQ_MODE      = {r_mode[1], r_mode[0]};
    REQ_CMD       = {r_cmd[1], r_cmd[0]};
    REQ_INP_VALID = {r_iv[1], r_iv[0]};
    REQ_CIN       = {r_cin[1], r_cin[0]};
    REQ_OPA       = {r_opa[1], r_opa[0]};
    REQ_OPB       = {r_opb[1], r_opb[0]};
  endtask

  task automatic do_reset;
    @(negedge CLK);
    RST = 1'b1; REQ_VALID = 2'b00;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    lg_model = 1'b1;
  endtask

  // Drives one request and records what the DUT did with it; callers compare.
  task automatic run_op(input logic [1:0] vmask, input bit keep,
                        output logic [1:0] grant, output int h_cyc, output int ce_cnt,
                        output bit stable, output bit got_rsp, output int rsp_dly,
                        output logic rsp_id, output logic [15:0] res, output logic [5:0] flags,
                        output bit both_ready);
    int idx;
    both_ready = 0; grant = 2'b00; stable = 1; got_rsp = 0; rsp_dly = 0;
    ce_cnt = 0; rsp_id = 1'b0; res = '0; flags = '0; h_cyc = 0;
    @(negedge CLK);
    REQ_VALID = vmask;
    for (int w = 0; w < 8 && grant == 2'b00; w++) begin
      #1;
      if (REQ_READY == 2'b11) both_ready = 1;
      if (REQ_READY != 2'b00) grant = REQ_READY;
      else @(negedge CLK);
    end
    h_cyc = cyc;
    if (grant == 2'b00) begin
      REQ_VALID = 2'b00;
      return;
    end
    idx = grant[1] ? 1 : 0;
    for (int k = 1; k <= 8 && !got_rsp; k++) begin
      @(negedge CLK);
      if (!keep) REQ_VALID = 2'b00;
      #1;
      if (REQ_READY == 2'b11) both_ready = 1;
      if (ALU_CE) begin
        ce_cnt++;
        if (ALU_MODE !== r_mode[idx] || ALU_CMD !== r_cmd[idx] || ALU_INP_VALID !== r_iv[idx] ||
            ALU_CIN !== r_cin[idx] || ALU_OPA !== r_opa[idx] || ALU_OPB !== r_opb[idx])
          stable = 0;
      end else if (ALU_OPA !== 8'd0 || ALU_OPB !== 8'd0 || ALU_CMD !== 4'd0 || ALU_MODE !== 1'b0)
        stable = 0;
      if (RSP_VALID) begin
        got_rsp = 1; rsp_dly = k; rsp_id = RSP_ID; res = RSP_RES; flags = RSP_FLAGS;
      end
    end
  endtask

  logic [1:0] g; int h, ce, dly; bit st, got, both; logic id; logic [15:0] res; logic [5:0] fl;

  task automatic test_reset;
    repeat (2) @(negedge CLK);
    #1;
    vectors++; if (REQ_READY !== 2'b00) begin miscompares++; $display("FAIL reset_ready: got %b want 00", REQ_READY); end
    vectors++; if (ALU_CE !== 1'b0) begin miscompares++; $display("FAIL reset_alu_ce: got %b want 0", ALU_CE); end
    vectors++; if ({ALU_MODE, ALU_CMD, ALU_INP_VALID, ALU_CIN, ALU_OPA, ALU_OPB} !== '0) begin
      miscompares++; $display("FAIL reset_alu_ports: got %h want 0", {ALU_MODE, ALU_CMD, ALU_INP_VALID, ALU_CIN, ALU_OPA, ALU_OPB}); end
    vectors++; if ({RSP_VALID, RSP_ID, RSP_RES, RSP_FLAGS} !== '0) begin
      miscompares++; $display("FAIL reset_rsp: got %h want 0", {RSP_VALID, RSP_ID, RSP_RES, RSP_FLAGS}); end
    REQ_VALID = 2'b00;
    RST = 1'b0;
    lg_model = 1'b1;
  endtask

  task automatic test_add;
    set_req(0, 1'b1, 4'd0, 2'b11, 1'b0, 8'd10, 8'd5);
    run_op(2'b01, 0, g, h, ce, st, got, dly, id, res, fl, both);
    vectors++; if (g !== 2'b01) begin miscompares++; $display("FAIL add_grant: got %b want 01", g); end
    vectors++; if (ce != 1 || !st) begin miscompares++; $display("FAIL add_ce: got %0d cycles stable=%0d want 1 stable=1", ce, st); end
    vectors++; if (!got || dly != 2) begin miscompares++; $display("FAIL add_rsp_time: got valid=%0d at H+%0d want H+2", got, dly); end
    vectors++; if (id !== 1'b0 || res !== 16'd15 || fl[0] !== 1'b0) begin
      miscompares++; $display("FAIL add_rsp: got id=%0d res=%0d err=%b want id=0 res=15 err=0", id, res, fl[0]); end
    lg_model = 1'b0;
  endtask

  task automatic test_mul;
    set_req(1, 1'b1, 4'd9, 2'b11, 1'b0, 8'd3, 8'd4);
    run_op(2'b10, 0, g, h, ce, st, got, dly, id, res, fl, both);
    vectors++; if (g !== 2'b10) begin miscompares++; $display("FAIL mul_grant: got %b want 10", g); end
    vectors++; if (ce != 2 || !st) begin miscompares++; $display("FAIL mul_ce: got %0d cycles stable=%0d want 2 stable=1", ce, st); end
    vectors++; if (!got || dly != 3) begin miscompares++; $display("FAIL mul_rsp_time: got valid=%0d at H+%0d want H+3", got, dly); end
    vectors++; if (id !== 1'b1 || res !== 16'd20) begin
      miscompares++; $display("FAIL mul_rsp: got id=%0d res=%0d want id=1 res=20", id, res); end
    lg_model = 1'b1;
  endtask

  task automatic test_back_to_back;
    int prev_h;
    do_reset();
    set_req(0, 1'b1, 4'd0, 2'b11, 1'b0, 8'd1, 8'd2);
    set_req(1, 1'b1, 4'd0, 2'b11, 1'b0, 8'd30, 8'd40);
    prev_h = 0;
    for (int i = 0; i < 4; i++) begin
      run_op(2'b11, 1, g, h, ce, st, got, dly, id, res, fl, both);
      vectors++; if (g !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        miscompares++; $display("FAIL b2b_grant%0d: got %b want %b", i, g, (i % 2 == 0) ? 2'b01 : 2'b10); end
      vectors++; if (both) begin miscompares++; $display("FAIL b2b_ready_both%0d: got 11 want onehot", i); end
      vectors++; if (!got || id !== i[0] || res !== ((i % 2 == 0) ? 16'd3 : 16'd70)) begin
        miscompares++; $display("FAIL b2b_rsp%0d: got id=%0d res=%0d", i, id, res); end
      if (i > 0) begin
        vectors++; if (h - prev_h != 3) begin miscompares++; $display("FAIL b2b_spacing%0d: got %0d want 3", i, h - prev_h); end
      end
      prev_h = h;
    end
    REQ_VALID = 2'b00;
    lg_model = 1'b1;
  endtask

  task automatic test_reset_mid;
    bit seen;
    do_reset();
    set_req(0, 1'b1, 4'd0, 2'b11, 1'b0, 8'd7, 8'd8);
    run_op(2'b01, 0, g, h, ce, st, got, dly, id, res, fl, both);
    set_req(1, 1'b1, 4'd9, 2'b11, 1'b0, 8'd5, 8'd6);
    @(negedge CLK);
    REQ_VALID = 2'b10; #1;
    vectors++; if (REQ_READY !== 2'b10) begin miscompares++; $display("FAIL rmid_handshake: got %b want 10", REQ_READY); end
    @(negedge CLK);
    REQ_VALID = 2'b00; RST = 1'b1; #1;
    vectors++; if (ALU_CE !== 1'b1) begin miscompares++; $display("FAIL rmid_ce_before: got %b want 1", ALU_CE); end
    @(negedge CLK);
    REQ_VALID = 2'b01; #1;
    vectors++; if (REQ_READY !== 2'b00) begin miscompares++; $display("FAIL rmid_ready_in_rst: got %b want 00", REQ_READY); end
    vectors++; if ({ALU_CE, ALU_MODE, ALU_CMD, ALU_INP_VALID, ALU_OPA, ALU_OPB, RSP_VALID, RSP_RES, RSP_FLAGS} !== '0) begin
      miscompares++; $display("FAIL rmid_outputs: got ce=%b opa=%h rsp_valid=%b res=%h want all 0", ALU_CE, ALU_OPA, RSP_VALID, RSP_RES); end
    REQ_VALID = 2'b00; RST = 1'b0; lg_model = 1'b1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin @(negedge CLK); #1; if (RSP_VALID) seen = 1; end
    vectors++; if (seen) begin miscompares++; $display("FAIL rmid_no_rsp: got RSP_VALID=1 want 0"); end
    set_req(1, 1'b1, 4'd0, 2'b11, 1'b0, 8'd1, 8'd1);
    run_op(2'b11, 0, g, h, ce, st, got, dly, id, res, fl, both);
    vectors++; if (g !== 2'b01 || id !== 1'b0) begin miscompares++; $display("FAIL rmid_next_grant: got %b id=%0d want 01 id=0", g, id); end
    lg_model = 1'b0;
  endtask

  task automatic test_inp_valid_zero;
    set_req(0, 1'b1, 4'd0, 2'b00, 1'b0, 8'd9, 8'd9);
    run_op(2'b01, 0, g, h, ce, st, got, dly, id, res, fl, both);
    vectors++; if (g !== 2'b01 || ce != 1 || !st) begin
      miscompares++; $display("FAIL iv0_forward: got grant=%b ce=%0d stable=%0d want 01 1 1", g, ce, st); end
    vectors++; if (!got || id !== 1'b0 || fl[0] !== 1'b1) begin
      miscompares++; $display("FAIL iv0_err: got valid=%0d id=%0d err=%b want 1 0 1", got, id, fl[0]); end
    lg_model = 1'b0;
  endtask

  task automatic test_idle_hold;
    int bad;
    set_req(1, 1'b1, 4'd0, 2'b11, 1'b0, 8'd100, 8'd27);
    run_op(2'b10, 0, g, h, ce, st, got, dly, id, res, fl, both);
    vectors++; if (!got || res !== 16'd127 || id !== 1'b1) begin
      miscompares++; $display("FAIL hold_setup: got res=%0d id=%0d want 127 1", res, id); end
    lg_model = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK); #1;
      vectors++;
      if (ALU_CE !== 1'b0 || RSP_VALID !== 1'b0 || RSP_RES !== 16'd127 || RSP_ID !== 1'b1) begin
        miscompares++; $display("FAIL hold_cycle%0d: got ce=%b rv=%b res=%0d id=%b want 0 0 127 1", k, ALU_CE, RSP_VALID, RSP_RES, RSP_ID);
      end
    end
  endtask

  task automatic test_random;
    logic [1:0] vm;
    logic win;
    int lat;
    logic [21:0] exp;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++)
        set_req(i, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 1) == 1) ? 4'd9 : 4'd10) : 4'($urandom_range(0, 15)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      vm = 2'($urandom_range(1, 3));
      win = (vm == 2'b01) ? 1'b0 : (vm == 2'b10) ? 1'b1 : ~lg_model;
      lat = op_lat(r_mode[win], r_cmd[win]);
      exp = alu_fn(r_mode[win], r_cmd[win], r_iv[win], r_cin[win], r_opa[win], r_opb[win]);
      run_op(vm, 0, g, h, ce, st, got, dly, id, res, fl, both);
      vectors++;
      if (g !== (win ? 2'b10 : 2'b01) || both || ce != lat || !st || !got || dly != lat + 1 ||
          id !== win || {fl, res} !== exp) begin
        miscompares++;
        $display("FAIL rand%0d: got grant=%b ce=%0d st=%0d dly=%0d id=%0d rsp=%h want grant=%b ce=%0d dly=%0d id=%0d rsp=%h",
                 n, g, ce, st, dly, id, {fl, res}, win ? 2'b10 : 2'b01, lat, lat + 1, win, exp);
      end
      lg_model = win;
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
  endtask

  initial begin
    lg_model = 1'b1;
    for (int i = 0; i < 2; i++) set_req(i, 1'b0, 4'd0, 2'b00, 1'b0, 8'd0, 8'd0);
    test_reset();
    test_add();
    test_mul();
    test_back_to_back();
    test_reset_mid();
    test_inp_valid_zero();
    test_idle_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU_DESIGN instance between two requesters.
- Grants the ALU round-robin, latches the winner's operation, and drives the ALU ports for exactly the command's latency.
- Samples RES and the flags, then returns them to the winner as a one-cycle tagged response.
- Sits between the requester-side logic and the ALU in the datapath top level.

Parameters:
- DW, 8, operand width (matches ALU DW).
- CW, 4, command width (matches ALU CW).
- LAT, 1, ALU latency in cycles for all non-multiply commands (>=1).
- MUL_LAT, 2, ALU latency for multiply commands (MODE=1, CMD=9 or 10), >=1.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- REQ_VALID  in  2  per-requester request; bit i = requester i.
- REQ_READY  out  2  per-requester accept; handshake when VALID&READY.
- REQ_MODE  in  2  per-requester MODE.
- REQ_CMD  in  2*CW  per-requester CMD; requester i at [i*CW +: CW].
- REQ_INP_VALID  in  4  per-requester INP_VALID, 2 bits each.
- REQ_CIN  in  2  per-requester CIN.
- REQ_OPA  in  2*DW  per-requester OPA.
- REQ_OPB  in  2*DW  per-requester OPB.
- ALU_CE  out  1  to ALU CE.
- ALU_MODE  out  1  to ALU MODE.
- ALU_CMD  out  CW  to ALU CMD.
- ALU_INP_VALID  out  2  to ALU INP_VALID.
- ALU_CIN  out  1  to ALU CIN.
- ALU_OPA  out  DW  to ALU OPA.
- ALU_OPB  out  DW  to ALU OPB.
- ALU_RES  in  2*DW  from ALU RES.
- ALU_FLAGS  in  6  {COUT,OFLOW,G,L,E,ERR} from ALU.
- RSP_VALID  out  1  one-cycle response pulse.
- RSP_ID  out  1  requester index of the response.
- RSP_RES  out  2*DW  captured RES.
- RSP_FLAGS  out  6  captured flags, same order as ALU_FLAGS.

Behaviour:
- Reset:
  - One clock and synchronous active-high reset (CLK, RST).
  - RST sampled high: state <= IDLE; last_grant <= 1, so requester 0 wins first.
  - All registered outputs <= 0: ALU_*, RSP_*.
  - REQ_READY = 0 while RST is high.
- Reset mid-operation aborts the operation: no RSP_VALID, ALU_CE drops the next cycle, and the ALU result is discarded.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Winner: if exactly one REQ_VALID bit is set, that requester; if both, the requester != last_grant.
  - REQ_READY is combinational: only the winner's bit is high, only in IDLE, never both bits.
  - On handshake (cycle H), latch MODE/CMD/INP_VALID/CIN/OPA/OPB and the winner ID; last_grant <= winner.
  - Load counter with L = MUL_LAT if (MODE=1 and CMD in {9,10}), else LAT; go to BUSY.
- BUSY:
  - ALU_CE=1 and ALU_* hold the latched values in cycles H+1 .. H+L, stable throughout.
  - The counter decrements each cycle; when it reaches 1, capture ALU_RES/ALU_FLAGS at that edge (end of cycle H+L) and go to RESP.
- RESP:
  - Cycle H+L+1: RSP_VALID=1, RSP_ID=winner, RSP_RES/RSP_FLAGS hold the captured values.
  - ALU_CE=0 and ALU_* return to 0.
  - Next state IDLE.
- Outside BUSY: ALU_CE=0 and all ALU_* = 0.
- Outside RESP: RSP_VALID=0; RSP_RES/RSP_FLAGS/RSP_ID hold their last values.
- Earliest next handshake is H+L+2, so one operation per L+2 cycles.
- No response backpressure: requesters sample the RSP_VALID pulse.
- Operations are not inspected: INP_VALID=00 or an illegal CMD is forwarded, and the ALU ERR is returned in RSP_FLAGS[0].
- A requester may drop REQ_VALID before READY without penalty; requests are never queued internally.
- Both requesters continuously valid: grants strictly alternate 0,1,0,1.

Test Plan:
- After reset, req0 only: MODE=1, CMD=0 (ADD), INP_VALID=11, OPA=10, OPB=5, handshake at H -> ALU_CE high only in H+1; RSP_VALID at H+2 with RSP_ID=0, RSP_RES=15, ERR=0.
- req1 multiply: MODE=1, CMD=9, OPA=3, OPB=4 -> ALU_CE high for H+1..H+2 with stable operands; RSP_VALID at H+3 with RSP_ID=1, RSP_RES=20.
- Both REQ_VALID held high for 4 operations straight after reset -> grant order 0,1,0,1; REQ_READY is never 2'b11; handshakes spaced LAT+2=3 cycles apart.
- RST asserted in the cycle after a multiply handshake -> no RSP_VALID; all outputs 0 next cycle; the next grant goes to requester 0.
- req0 with INP_VALID=00 -> operation forwarded unchanged; RSP_FLAGS[0] (ERR) equals the ALU ERR (1); RSP_ID=0.
- No request for 10 cycles after a response -> ALU_CE=0, RSP_VALID=0, and RSP_RES holds its last value throughout.
